// File: rtl/line_clear_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_clear_scan: bottom-up full-row scan that compacts the board in place |
// | Optional: LINE_SCAN_TOTAL_EN adds o_total_lines.     Rev 1.0             |
// +--------------------------------------------------------------------------+
module line_clear_scan #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  output logic [AW-1:0]   o_rd_addr,
  input  logic [COLS-1:0] i_rd_data,
  output logic            o_wr_en,
  output logic [AW-1:0]   o_wr_addr,
  output logic [COLS-1:0] o_wr_data,
  output logic            o_busy,
  output logic            o_hit,
  output logic [1:0]      o_line_count,
  output logic            o_done
`ifdef LINE_SCAN_TOTAL_EN
  ,
  output logic [9:0]      o_total_lines
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EVAL = 3'd2,
    S_CLR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [AW-1:0] c_LAST = AW'(ROWS - 1);

  state_t        r_state, w_next;
  logic [AW-1:0] r_row, w_row_nxt;
  logic [AW-1:0] r_wptr, w_wptr_nxt;
  logic [4:0]    r_cnt, w_cnt_nxt;
  logic          r_busy, r_hit, r_done;
  logic [1:0]    r_line_count;
  logic          w_accept, w_full, w_done_st;
  logic [1:0]    w_lc;

  assign w_accept  = (r_state == S_IDLE) && i_start && !r_busy;
  assign w_full    = &i_rd_data;
  assign w_done_st = (r_state == S_DONE);
  assign w_lc      = (r_cnt >= 5'd4) ? 2'd3 : (r_cnt[1:0] - 2'd1);

  always_comb begin
    w_next     = r_state;
    w_row_nxt  = r_row;
    w_wptr_nxt = r_wptr;
    w_cnt_nxt  = r_cnt;
    o_rd_addr  = '0;
    o_wr_en    = 1'b0;
    o_wr_addr  = '0;
    o_wr_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next     = S_RD;
          w_row_nxt  = c_LAST;
          w_wptr_nxt = c_LAST;
          w_cnt_nxt  = '0;
        end
      end
      S_RD: begin
        o_rd_addr = r_row;
        w_next    = S_EVAL;
      end
      S_EVAL: begin
        if (w_full) begin
          if (r_cnt != 5'd31) w_cnt_nxt = r_cnt + 5'd1;
        end else begin
          // Rows below the first full row are already in place; skip rewriting them.
          if (r_cnt != 5'd0) begin
            o_wr_en   = 1'b1;
            o_wr_addr = r_wptr;
            o_wr_data = i_rd_data;
          end
          w_wptr_nxt = r_wptr - 1'b1;
        end
        if (r_row == '0) begin
          w_next = (w_cnt_nxt != 5'd0) ? S_CLR : S_DONE;
        end else begin
          w_row_nxt = r_row - 1'b1;
          w_next    = S_RD;
        end
      end
      S_CLR: begin
        o_wr_en    = 1'b1;
        o_wr_addr  = r_wptr;
        w_wptr_nxt = r_wptr - 1'b1;
        if (r_wptr == '0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_wptr       <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_hit        <= 1'b0;
      r_done       <= 1'b0;
      r_line_count <= 2'd0;
    end else begin
      r_state <= w_next;
      r_row   <= w_row_nxt;
      r_wptr  <= w_wptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_st;
      r_hit   <= w_done_st && (r_cnt != 5'd0);
      if (w_done_st && (r_cnt != 5'd0)) r_line_count <= w_lc;
      // Busy spans through the done pulse so a start in that cycle is dropped.
      if (w_accept)    r_busy <= 1'b1;
      else if (r_done) r_busy <= 1'b0;
    end
  end

  assign o_busy       = r_busy;
  assign o_hit        = r_hit;
  assign o_done       = r_done;
  assign o_line_count = r_line_count;

`ifdef LINE_SCAN_TOTAL_EN
  logic [9:0]  r_total;
  logic [10:0] w_total_sum;

  assign w_total_sum = {1'b0, r_total} + {6'd0, r_cnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total <= 10'd0;
    end else if (w_done_st) begin
      r_total <= (w_total_sum > 11'd999) ? 10'd999 : w_total_sum[9:0];
    end
  end

  assign o_total_lines = r_total;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_clear_scan.sv
`default_nettype none
// Randomized and directed board scans checked against a row-compaction model.
module tb_line_clear_scan;

  typedef logic [9:0] board_t [20];

  logic       clk, rst, i_start, load;
  logic [4:0] o_rd_addr, o_wr_addr;
  logic [9:0] i_rd_data, o_wr_data;
  logic       o_wr_en, o_busy, o_hit, o_done;
  logic [1:0] o_line_count;
`ifdef LINE_SCAN_TOTAL_EN
  logic [9:0] o_total_lines;
  int         m_total;
`endif

  board_t board, init_board, exp_b;
  int     n_cmp, n_fail;
  int     m_cyc, m_D, m_cnt;
  logic [1:0] m_lc;

  line_clear_scan dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_hit        (o_hit),
    .o_line_count (o_line_count),
    .o_done       (o_done)
`ifdef LINE_SCAN_TOTAL_EN
    ,
    .o_total_lines(o_total_lines)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board memory with one-cycle synchronous read.
  always @(posedge clk) begin
    if (load) board <= init_board;
    else if (o_wr_en) board[o_wr_addr] <= o_wr_data;
    i_rd_data <= board[o_rd_addr];
  end

  function automatic int count_full(input board_t b);
    int n;
    n = 0;
    for (int r = 0; r < 20; r++) if (b[r] == 10'h3FF) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: scan accepted -> cycles 1..D busy, done/hit at D=42+cleared.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= 0;
      m_D   <= 0;
      m_cnt <= 0;
      m_lc  <= 2'd0;
`ifdef LINE_SCAN_TOTAL_EN
      m_total <= 0;
`endif
    end else if (m_cyc == 0) begin
      if (i_start) begin
        m_cyc <= 1;
        m_cnt <= count_full(board);
        m_D   <= 42 + count_full(board);
      end
    end else if (m_cyc == m_D) begin
      m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_cyc + 1 == m_D && m_cnt != 0) begin
        m_lc <= (m_cnt >= 4) ? 2'd3 : 2'(m_cnt - 1);
`ifdef LINE_SCAN_TOTAL_EN
        m_total <= (m_total + m_cnt > 999) ? 999 : m_total + m_cnt;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", o_busy, m_cyc > 0);
      check("done", o_done, m_cyc == m_D && m_cyc > 0);
      check("hit", o_hit, m_cyc == m_D && m_cyc > 0 && m_cnt != 0);
      check("line_count", o_line_count, m_lc);
      if (m_cyc == 0 || m_cnt == 0) check("wr_en_quiet", o_wr_en, 0);
`ifdef LINE_SCAN_TOTAL_EN
      check("total_lines", o_total_lines, m_total);
`endif
    end
  end

  task automatic run_case(input int repulse_at, output int done_at, output logic hit_seen);
    int n, w, ndone, k;
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    n = 0;
    w = 19;
    for (int r = 0; r < 20; r++) exp_b[r] = 10'h000;
    for (int r = 19; r >= 0; r--) begin
      if (init_board[r] == 10'h3FF) n++;
      else begin
        exp_b[w] = init_board[r];
        w--;
      end
    end
    done_at  = -1;
    hit_seen = 1'b0;
    ndone    = 0;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    k = 1;
    while (k <= 100 && !(done_at > 0 && k >= done_at + 2)) begin
      i_start = (k == repulse_at);
      @(negedge clk);
      if (o_done) begin
        ndone++;
        if (done_at < 0) begin
          done_at  = k;
          hit_seen = o_hit;
        end
      end
      @(posedge clk); #1;
      k++;
    end
    i_start = 1'b0;
    check("done_cycle", done_at, 42 + n);
    check("done_count", ndone, 1);
    for (int r = 0; r < 20; r++) check("board_row", board[r], exp_b[r]);
  endtask

  int   d_at;
  logic h;

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; i_start = 1'b0; load = 1'b0;
    for (int r = 0; r < 20; r++) init_board[r] = 10'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_hit", o_hit, 0);
    check("rst_wr_en", o_wr_en, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    check("rst_rd_addr", o_rd_addr, 0);
    check("rst_lc", o_line_count, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Empty board
    run_case(0, d_at, h);
    check("empty_done_at", d_at, 42);
    check("empty_hit", h, 0);

    // One full row at the bottom
    init_board[19] = 10'h3FF; init_board[18] = 10'h201;
    run_case(0, d_at, h);
    check("one_done_at", d_at, 43);
    check("one_row19", board[19], 10'h201);
    check("one_row0", board[0], 10'h000);
    check("one_hit", h, 1);
    check("one_lc", o_line_count, 2'b00);

    // Four full rows
    for (int r = 0; r < 20; r++) init_board[r] = 10'h000;
    for (int r = 16; r < 20; r++) init_board[r] = 10'h3FF;
    init_board[15] = 10'h155;
    run_case(0, d_at, h);
    check("four_row19", board[19], 10'h155);
    check("four_row15", board[15], 10'h000);
    check("four_lc", o_line_count, 2'b11);
    check("four_done_at", d_at, 46);

    // Non-adjacent full rows, with a start re-pulse mid-scan
    for (int r = 0; r < 20; r++) init_board[r] = 10'h000;
    init_board[19] = 10'h3FF; init_board[17] = 10'h3FF; init_board[18] = 10'h00F;
    run_case(10, d_at, h);
    check("gap_row19", board[19], 10'h00F);
    check("gap_row18", board[18], 10'h000);
    check("gap_lc", o_line_count, 2'b01);

    // Whole board full: saturated line count, every row zeroed
    for (int r = 0; r < 20; r++) init_board[r] = 10'h3FF;
    run_case(0, d_at, h);
    check("full_done_at", d_at, 62);
    check("full_lc", o_line_count, 2'b11);

    // Randomized boards
    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < 20; r++)
        init_board[r] = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 1022));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_case(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : 0, d_at, h);
    end

    // Reset in the middle of a shift write
    for (int r = 0; r < 20; r++) init_board[r] = 10'($urandom_range(0, 1022));
    init_board[19] = 10'h3FF;
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    check("mid_wr_en_before", o_wr_en, 1);
    check("mid_busy_before", o_busy, 1);
    rst = 1'b1;
    #1;
    check("mid_busy_rst", o_busy, 0);
    check("mid_wr_en_rst", o_wr_en, 0);
    check("mid_hit_rst", o_hit, 0);
    @(posedge clk); #1 rst = 1'b0;

    init_board[19] = 10'h3FF; init_board[18] = 10'h0F0;
    run_case(0, d_at, h);
    check("post_rst_lc", o_line_count, 2'b00);

`ifdef LINE_SCAN_TOTAL_EN
    for (int t = 0; t < 252; t++) begin
      for (int r = 0; r < 20; r++) init_board[r] = 10'h000;
      for (int r = 16; r < 20; r++) init_board[r] = 10'h3FF;
      init_board[15] = 10'($urandom_range(0, 1022));
      run_case(0, d_at, h);
    end
    check("total_saturated", o_total_lines, 10'd999);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_clear_scan.md
# line_clear_scan

Upstream feeder of the score counter. After a falling piece locks, it scans the playfield row memory bottom-up and finds every completely filled row. It compacts the board in place by shifting surviving rows down and zero-filling the top. It then pulses `hit` with the encoded `lineCount` that the score stage consumes, plus a `done` pulse for the game controller on every scan, including scans that clear nothing.

## Interface
- `ROWS`, 20, playfield height; row 0 = top, row `ROWS-1` = bottom
- `COLS`, 10, playfield width, one bit per cell (1 = occupied)
- `AW`, 5, row address width; must satisfy 2^AW >= ROWS

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to scan; ignored while `busy`=1
- `rd_addr`  out  AW  board read address; memory has 1-cycle synchronous read
- `rd_data`  in  COLS  row contents, valid the cycle after `rd_addr` is driven
- `wr_en`  out  1  board write strobe
- `wr_addr`  out  AW  board write address
- `wr_data`  out  COLS  board write data
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `hit`  out  1  one-cycle pulse, only when >=1 row was cleared
- `lineCount`  out  2  cleared rows minus 1 (00=1 … 11=4); held until next `hit`
- `done`  out  1  one-cycle pulse at the end of every scan

## Operation
- States: IDLE, RD, EVAL, CLR, DONE.
- IDLE: `start`=1 → load `r`=ROWS-1, `w`=ROWS-1, `cnt`=0 → RD.
- RD: drive `rd_addr`=`r` → EVAL.
- EVAL: `rd_data` valid.
  - If all COLS bits are 1: `cnt`++ (5-bit, no wrap) and no write.
  - Otherwise, if `cnt`≠0: write `rd_data` to `wr_addr`=`w`. Then `w`--.
  - If `r`=0 → CLR when `cnt`≠0, else DONE. Otherwise `r`-- → RD.
- CLR: write `wr_data`=0 to `wr_addr`=`w`, then `w`--. Leave when `w` reaches 0 after that write; exactly `cnt` zero rows are written (rows 0..cnt-1) → DONE.
- DONE: pulse `done`.
  - If `cnt`≠0: pulse `hit` and set `lineCount`=min(`cnt`,4)-1.
  - `cnt`>4 cannot occur in play; if it does, every full row is still removed and `lineCount` saturates at 11.
  - → IDLE.
- An all-zero board and a board with no full rows are both scanned and produce no writes, no `hit`, and one `done`.
- `start` while `busy` is dropped with no queuing. `start` in the same cycle as DONE is also ignored.

## Timing
- Reset values: state IDLE, `busy`=0, `hit`=0, `done`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0, `lineCount`=00.
- Reset mid-scan returns to IDLE immediately and `wr_en` drops asynchronously. Board contents are then undefined; the game controller always reinitialises the board on reset.
- Per row: 2 cycles (RD, EVAL). Scan length: 2·ROWS + `cnt` + 1 cycles from the first RD to DONE.
- For ROWS=20: `done` at cycle 42+`cnt` after the `start` edge, counting the `start` cycle as 0.
- `wr_en` is asserted only in EVAL (shift writes) and CLR. There is at most one write per cycle, and a read and a write never target the same row in the same cycle (`w`>=`r`).
- `hit` and `done` coincide in the same cycle; `busy` falls the cycle after DONE.

## Configuration
- `LINE_SCAN_TOTAL_EN` defined:
  - Adds output `total_lines` [9:0], the sum of rows cleared since reset.
  - Increments by `cnt` in the DONE cycle, saturates at 999 for the 3-digit display, resets to 0.
- Not defined: the port and its adder are absent; all other behaviour is identical.

## Test plan
- Empty 20×10 board, `start` → no `wr_en` ever, `hit`=0, `done` pulse at cycle 42.
- Row 19 = 0x3FF, row 18 = 0x201, others 0, `start` → row 19 written 0x201, row 0 written 0; `hit` with `lineCount`=00; `done` at cycle 43.
- Rows 16–19 all 0x3FF, row 15 = 0x155 → row 19 = 0x155, rows 0–3 zeroed; `lineCount`=11; (`LINE_SCAN_TOTAL_EN`) `total_lines`=4.
- Non-adjacent full rows 17 and 19, row 18 = 0x00F → row 19 = 0x00F, rows 0–1 zeroed; `lineCount`=01.
- `start` re-pulsed at cycle 10 of a scan → ignored, single `done`. `rst` asserted at cycle 20 → `busy`, `wr_en`, `hit` go to 0 in the same cycle.
- (`LINE_SCAN_TOTAL_EN`) 250 scans, each clearing 4 rows → `total_lines` saturates at 999 and stays at 999 on further clears.
